// File: rtl/reg_file_8x16.sv
// ---------------------------------------------------------------------------
// reg_file_8x16
//   Single-port register file built from flip-flops. It stores `depth` words
//   of `width` bits. One address bus serves both writes and reads. Read data
//   is registered.
//
// Ports
//   CLK      in   1           clock, rising edge
//   RST      in   1           synchronous reset, active-high; clears every
//                             word and rd_data, and overrides wr_en/rd_en
//   wr_data  in   width       data written on a write cycle
//   address  in   addressBus  word index for both write and read (unsigned)
//   wr_en    in   1           write enable (acts only when rd_en=0)
//   rd_en    in   1           read enable  (acts only when wr_en=0)
//   rd_data  out  width       registered read data; holds between reads
//
// Behaviour notes
//   - wr_en and rd_en both high is a no-op. Memory and rd_data both hold.
//   - An address with no matching word (address >= depth) never hits a word.
//     A write to it is dropped and a read of it returns 0.
// ---------------------------------------------------------------------------
module reg_file_8x16 #(
    parameter int width      = 16,
    parameter int depth      = 8,
    parameter int addressBus = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [width-1:0]      wr_data,
    input  logic [addressBus-1:0] address,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [width-1:0]      rd_data
);

    // A write or read happens only when exactly one enable is asserted.
    logic do_wr;
    logic do_rd;

    assign do_wr = wr_en & ~rd_en;
    assign do_rd = rd_en & ~wr_en;

    // Per-word contributions to the read mux. A word that is not addressed
    // contributes zero, so OR-ing all of them selects the addressed word.
    // An out-of-range address selects nothing and yields 0.
    logic [depth-1:0][width-1:0] rd_terms;

    generate
        for (genvar gi = 0; gi < depth; gi++) begin : gen_word
            logic             word_hit;
            logic [width-1:0] word_q;
            logic [width-1:0] word_d;

            assign word_hit = (address == addressBus'(gi));

            always_comb begin
                word_d = word_q;
                if (do_wr && word_hit) begin
                    word_d = wr_data;
                end
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    word_q <= '0;
                end else begin
                    word_q <= word_d;
                end
            end

            assign rd_terms[gi] = word_hit ? word_q : '0;
        end
    endgenerate

    logic [width-1:0] rd_sel;
    logic [width-1:0] rd_data_q;
    logic [width-1:0] rd_data_d;

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < depth; i++) begin
            rd_sel = rd_sel | rd_terms[i];
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (do_rd) begin
            rd_data_d = rd_sel;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_reg_file_8x16.sv
// ---------------------------------------------------------------------------
// tb_reg_file_8x16
//   Directed testbench for reg_file_8x16. It uses the default configuration
//   of 8 words x 16 bits. Inputs change 1 ns after a rising edge, and outputs
//   are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_reg_file_8x16;

    logic        clk;
    logic        rst;
    logic [15:0] wr_data;
    logic [2:0]  address;
    logic        wr_en;
    logic        rd_en;
    logic [15:0] rd_data;

    int n_checks;
    int n_fail;

    reg_file_8x16 #(
        .width      (16),
        .depth      (8),
        .addressBus (3)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .wr_data (wr_data),
        .address (address),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .rd_data (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs,
                            input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%04h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // This task writes one word. rd_data must not move on a write cycle.
    task automatic do_write(input logic [2:0] a, input logic [15:0] d,
                            input logic [15:0] hold_exp);
        address = a;
        wr_data = d;
        wr_en   = 1'b1;
        rd_en   = 1'b0;
        tick();
        wr_en   = 1'b0;
        check_eq($sformatf("wr_hold a%0d", a), rd_data, hold_exp);
    endtask

    task automatic do_read(input logic [2:0] a, input logic [15:0] exp);
        address = a;
        rd_en   = 1'b1;
        wr_en   = 1'b0;
        tick();
        rd_en   = 1'b0;
        check_eq($sformatf("rd a%0d", a), rd_data, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        // A write is presented during reset. It must not be stored.
        wr_en    = 1'b1;
        rd_en    = 1'b0;
        address  = 3'd3;
        wr_data  = 16'hDEAD;

        tick();
        tick();
        check_eq("reset rd_data", rd_data, 16'h0000);
        rst   = 1'b0;
        wr_en = 1'b0;

        for (int i = 0; i < 8; i++) do_read(3'(i), 16'h0000);

        // Write/read sequence
        do_write(3'd2, 16'h00AA, 16'h0000);
        do_read (3'd2, 16'h00AA);
        do_write(3'd5, 16'h00BB, 16'h00AA);
        do_read (3'd5, 16'h00BB);
        do_read (3'd2, 16'h00AA);
        do_read (3'd5, 16'h00BB);

        // Both enables high: this is a no-op for two edges.
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 16'h1234;
        address = 3'd5;
        tick();
        check_eq("both_en edge1", rd_data, 16'h00BB);
        tick();
        check_eq("both_en edge2", rd_data, 16'h00BB);
        wr_en = 1'b0;
        rd_en = 1'b0;
        do_read(3'd5, 16'h00BB);

        // Fill all addresses, then read each one back.
        for (int i = 0; i < 8; i++) do_write(3'(i), 16'h1000 + 16'(i), 16'h00BB);
        for (int i = 0; i < 8; i++) do_read(3'(i), 16'h1000 + 16'(i));

        // Idle hold: the address changes while both enables stay low.
        for (int i = 0; i < 5; i++) begin
            address = 3'(i);
            wr_data = 16'hFFFF;
            tick();
            check_eq($sformatf("idle hold %0d", i), rd_data, 16'h1007);
        end

        // Full-width data
        do_write(3'd7, 16'hFFFF, 16'h1007);
        do_write(3'd0, 16'h8001, 16'h1007);
        do_read (3'd7, 16'hFFFF);
        do_read (3'd0, 16'h8001);

        // Reset mid-operation, with a write to address 4 presented.
        rst     = 1'b1;
        wr_en   = 1'b1;
        address = 3'd4;
        wr_data = 16'h5555;
        tick();
        check_eq("mid reset rd_data", rd_data, 16'h0000);
        rst   = 1'b0;
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) do_read(3'(i), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
